// File: rtl/gpio_irq_service_ctrl.sv
// rtl/gpio_irq_service_ctrl.sv - APB master sequencer servicing the GPIO bank interrupt
//
// Purpose:
//   On gpio_irq, reads the GPIO interrupt status register over APB, writes the
//   same word back to W1C-clear exactly the bits that were read, then presents
//   the captured word on a valid/ready event port. Counts spurious interrupts
//   (status read back as zero) and accepted events, and keeps a sticky error
//   flag for slave errors and transfer timeouts.
//
// Ports:
//   PCLK, PRESET            clock, asynchronous active-high reset
//   enable                  service enable, looked at only while idle
//   gpio_irq                GPIO bank global interrupt level
//   PSEL..PWDATA            APB master request outputs (registered)
//   PRDATA/PREADY/PSLVERR   APB slave response inputs
//   evt_valid/evt_status    event word to the consumer, held until evt_ready
//   evt_ready               consumer accepts the event word
//   busy                    sequencer is not idle
//   err / err_clr           sticky error flag and its clear pulse
//   spurious_cnt            saturating count of zero status reads
//   svc_cnt                 wrapping count of accepted events

module gpio_irq_service_ctrl #(
  parameter logic [7:0]  STATUS_ADDR = 8'h14,
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        enable,
  input  logic        gpio_irq,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        evt_valid,
  output logic [31:0] evt_status,
  input  logic        evt_ready,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic [7:0]  spurious_cnt,
  output logic [15:0] svc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_SETUP  = 3'd1,
    S_RD_ACCESS = 3'd2,
    S_WR_SETUP  = 3'd3,
    S_WR_ACCESS = 3'd4,
    S_PUSH      = 3'd5
  } state_t;

  localparam logic [3:0] HOLDOFF_V    = 4'(HOLDOFF);
  // The abort fires in the ACCESS cycle that would be the TIMEOUT-th wait.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [3:0]  holdoff_q;
  logic [7:0]  wait_q;
  logic [31:0] status_q;

  // Single sequential FSM: every output is a register updated together with
  // the state, so the output values always belong to the state being entered.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= S_IDLE;
      holdoff_q    <= 4'd0;
      wait_q       <= 8'd0;
      status_q     <= 32'd0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= 8'd0;
      PWDATA       <= 32'd0;
      evt_valid    <= 1'b0;
      evt_status   <= 32'd0;
      busy         <= 1'b0;
      err          <= 1'b0;
      spurious_cnt <= 8'd0;
      svc_cnt      <= 16'd0;
    end else begin
      // Clear first; any error set below in the same cycle overrides it.
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (holdoff_q != 4'd0) begin
            holdoff_q <= holdoff_q - 4'd1;
          end else if (enable && gpio_irq) begin
            state_q <= S_RD_SETUP;
            busy    <= 1'b1;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= STATUS_ADDR;
            PWDATA  <= 32'd0;
          end
        end

        S_RD_SETUP: begin
          state_q <= S_RD_ACCESS;
          PENABLE <= 1'b1;
          wait_q  <= 8'd0;
        end

        S_RD_ACCESS: begin
          if (PREADY) begin
            if (PSLVERR) begin
              // Read failed: nothing trustworthy to clear or report.
              err       <= 1'b1;
              state_q   <= S_IDLE;
              holdoff_q <= HOLDOFF_V;
              busy      <= 1'b0;
              PSEL      <= 1'b0;
              PENABLE   <= 1'b0;
              PADDR     <= 8'd0;
            end else begin
              status_q <= PRDATA;
              if (PRDATA == 32'd0) begin
                if (spurious_cnt != 8'hFF) begin
                  spurious_cnt <= spurious_cnt + 8'd1;
                end
                state_q   <= S_IDLE;
                holdoff_q <= HOLDOFF_V;
                busy      <= 1'b0;
                PSEL      <= 1'b0;
                PENABLE   <= 1'b0;
                PADDR     <= 8'd0;
              end else begin
                // Write back exactly the bits read, so later edges stay pending.
                state_q <= S_WR_SETUP;
                PENABLE <= 1'b0;
                PWRITE  <= 1'b1;
                PWDATA  <= PRDATA;
              end
            end
          end else if (wait_q == TIMEOUT_LAST) begin
            err       <= 1'b1;
            state_q   <= S_IDLE;
            holdoff_q <= HOLDOFF_V;
            busy      <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= 8'd0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end

        S_WR_SETUP: begin
          state_q <= S_WR_ACCESS;
          PENABLE <= 1'b1;
          wait_q  <= 8'd0;
        end

        S_WR_ACCESS: begin
          if (PREADY || (wait_q == TIMEOUT_LAST)) begin
            // The status is already captured, so a failed clear still
            // delivers the event; only the error flag records the failure.
            if (!PREADY || PSLVERR) begin
              err <= 1'b1;
            end
            state_q    <= S_PUSH;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= 8'd0;
            PWDATA     <= 32'd0;
            evt_valid  <= 1'b1;
            evt_status <= status_q;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end

        S_PUSH: begin
          if (evt_ready) begin
            svc_cnt    <= svc_cnt + 16'd1;
            evt_valid  <= 1'b0;
            evt_status <= 32'd0;
            state_q    <= S_IDLE;
            holdoff_q  <= HOLDOFF_V;
            busy       <= 1'b0;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          holdoff_q  <= HOLDOFF_V;
          busy       <= 1'b0;
          PSEL       <= 1'b0;
          PENABLE    <= 1'b0;
          PWRITE     <= 1'b0;
          PADDR      <= 8'd0;
          PWDATA     <= 32'd0;
          evt_valid  <= 1'b0;
          evt_status <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_irq_service_ctrl.sv
// tb/tb_gpio_irq_service_ctrl.sv - directed self-checking bench for gpio_irq_service_ctrl

module tb_gpio_irq_service_ctrl;

  logic        PCLK;
  logic        PRESET;
  logic        enable;
  logic        gpio_irq;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        evt_valid;
  logic [31:0] evt_status;
  logic        evt_ready;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic [7:0]  spurious_cnt;
  logic [15:0] svc_cnt;

  int total = 0;
  int bad   = 0;
  int writes_seen;
  int evts_seen;
  int psel_seen;
  int busy_seen;

  gpio_irq_service_ctrl dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .enable       (enable),
    .gpio_irq     (gpio_irq),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .evt_valid    (evt_valid),
    .evt_status   (evt_status),
    .evt_ready    (evt_ready),
    .busy         (busy),
    .err          (err),
    .err_clr      (err_clr),
    .spurious_cnt (spurious_cnt),
    .svc_cnt      (svc_cnt)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    PRESET = 1'b1; enable = 1'b0; gpio_irq = 1'b0; PRDATA = 32'd0;
    PREADY = 1'b1; PSLVERR = 1'b0; evt_ready = 1'b0; err_clr = 1'b0;

    // Reset state
    step(1);
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_evt_valid", evt_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_svc_cnt", svc_cnt, 16'd0);
    chk("rst_spurious", spurious_cnt, 8'd0);
    PRESET = 1'b0; enable = 1'b1;
    step(2);

    // Basic service, zero wait states
    PRDATA = 32'h0000_0005; evt_ready = 1'b1; gpio_irq = 1'b1;
    step(1);
    chk("rd_setup_psel", PSEL, 1'b1);
    chk("rd_setup_penable", PENABLE, 1'b0);
    chk("rd_setup_pwrite", PWRITE, 1'b0);
    chk("rd_setup_paddr", PADDR, 8'h14);
    step(1);
    chk("rd_access_penable", PENABLE, 1'b1);
    chk("rd_access_paddr", PADDR, 8'h14);
    step(1);
    chk("wr_setup_pwrite", PWRITE, 1'b1);
    chk("wr_setup_penable", PENABLE, 1'b0);
    chk("wr_setup_pwdata", PWDATA, 32'h5);
    step(1);
    chk("wr_access_penable", PENABLE, 1'b1);
    chk("latency_not_early", evt_valid, 1'b0);
    step(1);
    chk("basic_evt_valid", evt_valid, 1'b1);
    chk("basic_evt_status", evt_status, 32'h5);
    chk("push_psel_low", PSEL, 1'b0);
    gpio_irq = 1'b0;
    step(1);
    chk("basic_evt_drop", evt_valid, 1'b0);
    chk("basic_svc_cnt", svc_cnt, 16'd1);
    chk("basic_idle", busy, 1'b0);
    step(6);

    // Backpressure, late edge keeps the interrupt pending
    PRDATA = 32'h0000_0003; evt_ready = 1'b0; gpio_irq = 1'b1;
    step(3);
    PRDATA = 32'h0000_0100;
    step(2);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", evt_valid, 1'b1);
      chk("stall_status", evt_status, 32'h3);
      if (i < 9) step(1);
    end
    evt_ready = 1'b1;
    step(1);
    chk("bp_evt_drop", evt_valid, 1'b0);
    chk("bp_svc_cnt", svc_cnt, 16'd2);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("holdoff_idle", busy, 1'b0);
    end
    step(1);
    chk("holdoff_restart_busy", busy, 1'b1);
    chk("holdoff_restart_psel", PSEL, 1'b1);
    step(2);
    chk("late_pwdata", PWDATA, 32'h100);
    step(2);
    chk("late_evt_valid", evt_valid, 1'b1);
    chk("late_evt_status", evt_status, 32'h100);
    gpio_irq = 1'b0;
    step(1);
    chk("late_svc_cnt", svc_cnt, 16'd3);
    step(6);

    // Spurious reads, 300 services, saturation at 255
    PRDATA = 32'd0; gpio_irq = 1'b1; writes_seen = 0; evts_seen = 0;
    step(3);
    chk("spur_first", spurious_cnt, 8'd1);
    chk("spur_idle", busy, 1'b0);
    chk("spur_no_psel", PSEL, 1'b0);
    for (int n = 4; n <= 2096; n++) begin
      step(1);
      writes_seen += int'(PWRITE);
      evts_seen   += int'(evt_valid);
      if (n == 66)   chk("spur_10", spurious_cnt, 8'd10);
      if (n == 1774) chk("spur_254", spurious_cnt, 8'd254);
      if (n == 1781) chk("spur_255", spurious_cnt, 8'd255);
    end
    chk("spur_saturated", spurious_cnt, 8'd255);
    chk("spur_no_write", writes_seen, 0);
    chk("spur_no_event", evts_seen, 0);
    gpio_irq = 1'b0;
    step(6);

    // PSLVERR on read
    PRDATA = 32'h7; PSLVERR = 1'b1; gpio_irq = 1'b1;
    step(3);
    chk("slverr_err", err, 1'b1);
    chk("slverr_idle", busy, 1'b0);
    chk("slverr_no_write", PWRITE, 1'b0);
    chk("slverr_no_event", evt_valid, 1'b0);
    gpio_irq = 1'b0; PSLVERR = 1'b0;
    step(1);
    chk("slverr_svc_cnt", svc_cnt, 16'd3);
    step(6);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_clr", err, 1'b0);

    // Timeout: PREADY held low
    PREADY = 1'b0; gpio_irq = 1'b1;
    step(17);
    chk("to_last_wait_psel", PSEL, 1'b1);
    chk("to_last_wait_err", err, 1'b0);
    step(1);
    chk("to_abort_psel", PSEL, 1'b0);
    chk("to_abort_penable", PENABLE, 1'b0);
    chk("to_err", err, 1'b1);
    chk("to_idle", busy, 1'b0);
    gpio_irq = 1'b0; PREADY = 1'b1;
    step(6);

    // Reset in RD_ACCESS with PREADY low
    PREADY = 1'b0; PRDATA = 32'h22; gpio_irq = 1'b1;
    step(2);
    chk("pre_rst_access", PENABLE, 1'b1);
    PRESET = 1'b1;
    #1;
    chk("midrst_psel", PSEL, 1'b0);
    chk("midrst_penable", PENABLE, 1'b0);
    chk("midrst_evt_valid", evt_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_svc_cnt", svc_cnt, 16'd0);
    chk("midrst_spurious", spurious_cnt, 8'd0);
    PREADY = 1'b1;
    step(1);
    PRESET = 1'b0;
    step(1);
    chk("postrst_restart_psel", PSEL, 1'b1);
    chk("postrst_restart_busy", busy, 1'b1);
    step(4);
    chk("postrst_evt_valid", evt_valid, 1'b1);
    chk("postrst_evt_status", evt_status, 32'h22);
    gpio_irq = 1'b0;
    step(1);
    chk("postrst_svc_cnt", svc_cnt, 16'd1);
    step(6);

    // Enable gating, then enable dropped during WR_ACCESS with a write error
    enable = 1'b0; gpio_irq = 1'b1; psel_seen = 0; busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      psel_seen += int'(PSEL);
      busy_seen += int'(busy);
    end
    chk("gated_no_psel", psel_seen, 0);
    chk("gated_no_busy", busy_seen, 0);
    PRDATA = 32'h8000_0001; enable = 1'b1;
    step(3);
    chk("en_wr_setup", PWRITE, 1'b1);
    PSLVERR = 1'b1;
    step(1);
    chk("en_wr_access", PENABLE, 1'b1);
    enable = 1'b0; gpio_irq = 1'b0;
    step(1);
    chk("en_drop_evt_valid", evt_valid, 1'b1);
    chk("en_drop_evt_status", evt_status, 32'h8000_0001);
    chk("wr_slverr_err", err, 1'b1);
    PSLVERR = 1'b0;
    step(1);
    chk("en_drop_svc_cnt", svc_cnt, 16'd2);
    chk("en_drop_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
